shift_register_ctrl: RTL and testbench

Frame-level sequencer for the byte-wide `shift_register` delay line, DEPTH entries deep.
- Accepts a pixel stream with start-of-frame and end-of-frame markers, and drives the line's `shift_en` and `serial_in`.
- Keeps a DEPTH-bit valid-tag shadow of the line, so only real pixels are emitted at the line's `serial_out`.
- At end of frame, drains the line by shifting in zero padding.
- Sits between the pixel source and the shift register, one instance per delay line.

---
 rtl/shift_register_ctrl.sv | 116 +++++++++++
 tb/tb_shift_register_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctrl.sv
// Frame sequencer for a byte-wide shift_register delay line. It keeps a
// valid-tag shadow of the line so only real pixels are flagged at the output,
// and drains the line with zero pads at end of frame.
module shift_register_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sof,
  input  logic                  in_eof,
  output logic                  in_ready,
  input  logic                  abort,
  output logic                  sr_shift_en,
  output logic [DATA_WIDTH-1:0] sr_serial_in,
  input  logic [DATA_WIDTH-1:0] sr_serial_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  frame_done,
  output logic                  sync_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] tag_q;
  logic [CNT_W-1:0] occ_q;
  logic             done_q, done_d;
  logic             err_q, err_set;
  logic             accept, shift, tag_in, tag_out;

  // Next-state, shift decision and tag-in bit; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    shift    = 1'b0;
    tag_in   = 1'b0;
    err_set  = 1'b0;
    done_d   = 1'b0;
    in_ready = (state_q != S_FLUSH) && !abort;
    accept   = in_valid && in_ready;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_sof) begin
            shift   = 1'b1;
            tag_in  = 1'b1;
            state_d = in_eof ? S_FLUSH : S_ACTIVE;
          end else begin
            // Pixel outside a frame: drop it and flag the framing error.
            err_set = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          shift   = 1'b1;
          tag_in  = 1'b1;
          err_set = in_sof;
          if (in_eof) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        shift = 1'b1;
        // Last tagged pixel leaves the line on this pad shift.
        if (occ_q == CNT_W'(1) && tag_q[DEPTH-1]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      shift   = 1'b0;
      tag_in  = 1'b0;
      done_d  = 1'b0;
    end
    tag_out = shift && tag_q[DEPTH-1];
  end

  assign sr_shift_en  = shift;
  assign sr_serial_in = (shift && tag_in) ? in_data : '0;
  assign out_valid    = tag_out;
  assign out_data     = sr_serial_out;
  assign occupancy    = occ_q;
  assign frame_done   = done_q;
  assign sync_err     = err_q;

  // State, tag shadow and occupancy move in lockstep with the data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      occ_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_q | err_set;
      if (abort) begin
        tag_q <= '0;
        occ_q <= '0;
      end else if (shift) begin
        tag_q <= {tag_q[DEPTH-2:0], tag_in};
        if (tag_in && !tag_out)      occ_q <= occ_q + CNT_W'(1);
        else if (!tag_in && tag_out) occ_q <= occ_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl with DEPTH=4: delay line model, a per-cycle
// scoreboard based on shift-count latency, and literal frame-level checks.
module tb_shift_register_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, abort = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, sr_shift_en, out_valid, frame_done, sync_err;
  logic [DW-1:0] sr_serial_in, sr_serial_out, out_data;
  logic [CW-1:0] occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_register_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .in_ready(in_ready), .abort(abort),
    .sr_shift_en(sr_shift_en), .sr_serial_in(sr_serial_in),
    .sr_serial_out(sr_serial_out), .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy), .frame_done(frame_done), .sync_err(sync_err)
  );

  // External delay line the controller drives.
  logic [DW-1:0] line [DEPTH];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else if (sr_shift_en) begin
      for (int i = DEPTH-1; i > 0; i--) line[i] <= line[i-1];
      line[0] <= sr_serial_in;
    end
  end
  assign sr_serial_out = line[DEPTH-1];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic qchk(input string nm, input logic [DW-1:0] act[$], input logic [DW-1:0] exp[$]);
    int ok;
    ok = (act.size() == exp.size());
    if (ok != 0) for (int i = 0; i < exp.size(); i++) if (act[i] != exp[i]) ok = 0;
    total++;
    if (ok == 0) begin
      bad++;
      $display("FAIL %s: got %p want %p", nm, act, exp);
    end
  endtask

  // Model: each pixel records the shift number that loaded it and is due out
  // on the shift DEPTH later; occupancy is simply the count still pending.
  typedef struct { logic [DW-1:0] d; int idx; } pend_t;
  pend_t pend[$];
  int    sc = 0;
  logic  m_frame = 0, m_flush = 0, m_err = 0, m_done = 0;

  logic [DW-1:0] out_log[$];
  logic [DW-1:0] occ_log[$];
  int            done_cnt = 0, flush_cyc = 0;
  logic          last_shift = 0;

  always @(negedge clk) begin
    logic          e_ready, e_shift, e_ov, nd;
    logic [DW-1:0] e_sin, e_od;
    if (!rst_n) begin
      pend.delete();
      m_frame = 0; m_flush = 0; m_err = 0; m_done = 0;
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_sync_err", int'(sync_err), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_shift_en", int'(sr_shift_en), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_serial_in", int'(sr_serial_in), 0);
      last_shift = 0;
    end else begin
      chk("occupancy", int'(occupancy), pend.size());
      chk("frame_done", int'(frame_done), int'(m_done));
      chk("sync_err", int'(sync_err), int'(m_err));
      e_ready = !m_flush && !abort;
      e_shift = 0; e_sin = '0; e_ov = 0; e_od = '0; nd = 0;
      if (abort) begin
        pend.delete();
        m_frame = 0; m_flush = 0;
      end else if (m_flush) begin
        e_shift = 1;
        sc++;
        if (pend.size() > 0 && pend[0].idx + DEPTH == sc) begin
          e_ov = 1; e_od = pend[0].d; void'(pend.pop_front());
          if (pend.size() == 0) begin m_flush = 0; nd = 1; end
        end
      end else if (in_valid) begin
        if (!m_frame && !in_sof) m_err = 1;
        else begin
          if (m_frame && in_sof) m_err = 1;
          e_shift = 1; e_sin = in_data;
          sc++;
          if (pend.size() > 0 && pend[0].idx + DEPTH == sc) begin
            e_ov = 1; e_od = pend[0].d; void'(pend.pop_front());
          end
          pend.push_back('{d: in_data, idx: sc});
          m_frame = !in_eof;
          m_flush = in_eof;
        end
      end
      m_done = nd;
      chk("in_ready", int'(in_ready), int'(e_ready));
      chk("shift_en", int'(sr_shift_en), int'(e_shift));
      chk("serial_in", int'(sr_serial_in), int'(e_sin));
      chk("out_valid", int'(out_valid), int'(e_ov));
      if (e_ov) chk("out_data", int'(out_data), int'(e_od));
      if (last_shift) occ_log.push_back(DW'(occupancy));
      last_shift = sr_shift_en;
      if (out_valid) out_log.push_back(out_data);
      if (frame_done) done_cnt++;
      if (!in_ready && !abort) flush_cyc++;
    end
  end

  task automatic pix(input logic [DW-1:0] d, input logic s, input logic e);
    @(posedge clk); #1;
    in_valid = 1; in_data = d; in_sof = s; in_eof = e; abort = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 0; in_data = '0; in_sof = 0; in_eof = 0; abort = 0;
    end
  endtask

  task automatic clr();
    out_log.delete(); occ_log.delete(); done_cnt = 0; flush_cyc = 0;
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_occupancy", int'(occupancy), 0);
    rst_n = 1;
    idle(2);

    // Continuous 10-pixel frame.
    clr();
    for (int i = 1; i <= 10; i++) pix(DW'(i), i == 1, i == 10);
    idle(7);
    exp_q.delete();
    for (int i = 1; i <= 10; i++) exp_q.push_back(DW'(i));
    qchk("cont_out", out_log, exp_q);
    chk("cont_flush_cycles", flush_cyc, 4);
    chk("cont_done", done_cnt, 1);

    // Short two-pixel frame.
    clr();
    pix(8'hA1, 1, 0);
    pix(8'hA2, 0, 1);
    idle(7);
    qchk("short_out", out_log, '{8'hA1, 8'hA2});
    qchk("short_occ", occ_log, '{8'd1, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0});
    chk("short_flush_cycles", flush_cyc, 4);
    chk("short_done", done_cnt, 1);

    // Gapped 8-pixel frame.
    clr();
    for (int i = 1; i <= 8; i++) begin
      pix(DW'(i), i == 1, i == 8);
      if (i != 8) idle(1);
    end
    idle(7);
    exp_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back(DW'(i));
    qchk("gap_out", out_log, exp_q);
    chk("gap_done", done_cnt, 1);

    // Abort after three pixels, with a pixel offered during the abort.
    clr();
    pix(8'h01, 1, 0); pix(8'h02, 0, 0); pix(8'h03, 0, 0);
    @(posedge clk); #1;
    in_valid = 1; in_data = 8'h99; in_sof = 0; in_eof = 0; abort = 1;
    #3 chk("abort_in_ready", int'(in_ready), 0);
    idle(1);
    chk("abort_occupancy", int'(occupancy), 0);
    idle(5);
    chk("abort_out_cnt", out_log.size(), 0);
    chk("abort_done", done_cnt, 0);
    clr();
    for (int i = 0; i < 6; i++) pix(8'h11 + DW'(i), i == 0, i == 5);
    idle(7);
    qchk("post_abort_out", out_log, '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16});

    // Framing errors: pixels before sof, then a sof+eof single pixel.
    clr();
    pix(8'h31, 0, 0); pix(8'h32, 0, 0); pix(8'h33, 0, 0);
    idle(2);
    chk("err_sticky", int'(sync_err), 1);
    chk("err_occupancy", int'(occupancy), 0);
    chk("err_out_cnt", out_log.size(), 0);
    pix(8'h55, 1, 1);
    idle(7);
    qchk("single_out", out_log, '{8'h55});
    chk("single_flush_cycles", flush_cyc, DEPTH);

    // Reset in the middle of a flush.
    pix(8'h01, 1, 0); pix(8'h02, 0, 0); pix(8'h03, 0, 1);
    idle(1);
    @(posedge clk); #1;
    rst_n = 0;
    clr();
    idle(2);
    rst_n = 1;
    idle(8);
    chk("midrst_occupancy", int'(occupancy), 0);
    chk("midrst_sync_err", int'(sync_err), 0);
    chk("midrst_done", done_cnt, 0);
    chk("midrst_out_cnt", out_log.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
